// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic blocks: operation codes and a
// parity-reduction helper.
package logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Callers zero-extend to this width; zero padding does not change parity.
    localparam int PARITY_MAX_W = 1024;

    function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit bitwise logic core: y = f(a, b) selected by op.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, accumulator mode,
// zero/parity flags and an accepted-transaction counter.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_count
);

    logic             accept_p0;
    logic [WIDTH-1:0] opb_p0;
    logic [WIDTH-1:0] result_p0;

    // Stage p0: operand select and combinational operation
    assign in_ready  = !out_valid || out_ready;
    assign accept_p0 = in_valid && in_ready;
    assign opb_p0    = in_acc_sel ? acc_q : in_b;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (in_a),
        .b  (opb_p0),
        .op (in_op),
        .y  (result_p0)
    );

    // Stage p1: output register, flags and transaction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            txn_count  <= '0;
        end else if (accept_p0) begin
            out_valid  <= 1'b1;
            out_data   <= result_p0;
            out_zero   <= (result_p0 == '0);
            out_parity <= parity_of(PARITY_MAX_W'(result_p0));
            txn_count  <= txn_count + 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Clear takes priority over an accumulate in the same cycle
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc_q <= '0;
        end else if (accept_p0 && in_acc_sel) begin
            acc_q <= result_p0;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus randomized
// traffic compared against a truth-table reference model.
module tb_logic_unit_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          in_acc_sel;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_parity;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] txn_count;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc_sel (in_acc_sel),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .acc_q      (acc_q),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_valid, m_data, m_zero, m_par, m_acc, m_cnt;

    // Per-op truth table indexed by {a_bit, b_bit}
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                           4'b0001, 4'b1001, 4'b0011, 4'b1100};

    function automatic int ref_op(input int op, input int a, input int b);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            logic [3:0] row = tt[op];
            int idx = ((a >> i) & 1) * 2 + ((b >> i) & 1);
            if (row[idx]) r = r | (1 << i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("in_ready",   32'(in_ready),   32'((m_valid == 0) || out_ready));
        check("out_valid",  32'(out_valid),  32'(m_valid));
        check("out_data",   32'(out_data),   32'(m_data));
        check("out_zero",   32'(out_zero),   32'(m_zero));
        check("out_parity", 32'(out_parity), 32'(m_par));
        check("acc_q",      32'(acc_q),      32'(m_acc));
        check("txn_count",  32'(txn_count),  32'(m_cnt));
    endtask

    // Check against the model at negedge, then advance one clock
    task automatic step();
        int acc_in, res, rdy, acc_n;
        @(negedge clk);
        check_model();
        rdy    = (m_valid == 0) || out_ready;
        acc_in = m_acc;
        res    = ref_op(int'(in_op), int'(in_a), in_acc_sel ? acc_in : int'(in_b));
        acc_n  = m_acc;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_data = 0; m_zero = 0; m_par = 0; m_acc = 0; m_cnt = 0;
        end else begin
            if (in_valid && rdy) begin
                m_valid = 1;
                m_data  = res;
                m_zero  = (res == 0);
                m_par   = $countones(res) % 2;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                if (in_acc_sel) acc_n = res;
            end else if (out_ready) begin
                m_valid = 0;
            end
            m_acc = acc_clr ? 0 : acc_n;
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic sel);
        in_valid = v; in_a = a; in_b = b; in_op = op; in_acc_sel = sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] basic_exp [8] = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'hA5};

        m_valid = 0; m_data = 0; m_zero = 0; m_par = 0; m_acc = 0; m_cnt = 0;
        rst = 1; acc_clr = 0; out_ready = 1;
        drive(0, '0, '0, 3'd0, 0);
        @(posedge clk); #1;
        step();
        rst = 0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_acc_q",     32'(acc_q),     0);
        check("rst_txn_count", 32'(txn_count), 0);
        check("rst_in_ready",  32'(in_ready),  1);

        // Basic ops back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'hA5, 8'h3C, 3'(i), 0);
            step();
            check("basic_data",   32'(out_data),   32'(basic_exp[i]));
            check("basic_parity", 32'(out_parity), 0);
            check("basic_valid",  32'(out_valid),  1);
        end
        check("basic_count", 32'(txn_count), 8);

        // Zero flag
        drive(1, 8'h0F, 8'hF0, 3'b000, 0);
        step();
        check("zero_data",   32'(out_data),   8'h00);
        check("zero_flag",   32'(out_zero),   1);
        check("zero_parity", 32'(out_parity), 0);

        // Accumulate
        drive(0, '0, '0, 3'b001, 0);
        acc_clr = 1;
        step();
        acc_clr = 0;
        check("acc_clr_q", 32'(acc_q), 0);
        drive(1, 8'h01, 8'hFF, 3'b001, 1); step(); check("acc_d1", 32'(out_data), 8'h01);
        drive(1, 8'h02, 8'hFF, 3'b001, 1); step(); check("acc_d2", 32'(out_data), 8'h03);
        drive(1, 8'h80, 8'hFF, 3'b001, 1); step(); check("acc_d3", 32'(out_data), 8'h83);
        check("acc_q83", 32'(acc_q), 8'h83);
        drive(1, 8'h04, 8'hFF, 3'b001, 1);
        acc_clr = 1;
        step();
        acc_clr = 0;
        check("acc_clr_data", 32'(out_data), 8'h87);
        check("acc_clr_q0",   32'(acc_q),    0);

        // Backpressure
        drive(0, '0, '0, 3'd0, 0); step();
        out_ready = 0;
        drive(1, 8'h11, 8'h00, 3'b111, 0); step();
        check("bp_a_data",  32'(out_data), 8'h11);
        check("bp_stall_rdy", 32'(in_ready), 0);
        drive(1, 8'h22, 8'h00, 3'b111, 0); step();
        check("bp_hold1", 32'(out_data), 8'h11);
        step();
        check("bp_hold2", 32'(out_data), 8'h11);
        out_ready = 1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 1);
        step();
        check("bp_b_data",  32'(out_data),  8'h22);
        check("bp_b_valid", 32'(out_valid), 1);
        drive(0, '0, '0, 3'd0, 0); step();
        check("bp_drain_valid", 32'(out_valid), 0);
        check("bp_drain_hold",  32'(out_data),  8'h22);

        // Reset mid-stall with a non-zero accumulator
        out_ready = 0;
        drive(1, 8'h33, 8'h00, 3'b001, 1); step();
        check("ms_valid", 32'(out_valid), 1);
        check("ms_acc",   32'(acc_q),     8'h33);
        drive(0, '0, '0, 3'd0, 0);
        rst = 1; step(); rst = 0;
        check("ms_rst_valid", 32'(out_valid), 0);
        check("ms_rst_data",  32'(out_data),  0);
        check("ms_rst_acc",   32'(acc_q),     0);
        check("ms_rst_cnt",   32'(txn_count), 0);
        check("ms_rst_rdy",   32'(in_ready),  1);
        out_ready = 1;

        // Counter wrap
        for (int i = 1; i <= 17; i++) begin
            drive(1, 8'($urandom), 8'($urandom), 3'b111, 0);
            step();
            if (i == 16) check("wrap16", 32'(txn_count), 0);
            if (i == 17) check("wrap17", 32'(txn_count), 1);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  3'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            acc_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0; acc_clr = 0;
        drive(0, '0, '0, 3'd0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the two-input gate block: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Has a valid/ready handshake on input and output, one output register stage, an accumulator mode (operand B taken from an internal register), result flags and a transaction counter.
- Sits between a producer and a consumer on the datapath; used as the standard logic stage and as the bench target for gate-level operation checks.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of the accepted-transaction counter (>=1)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored when in_acc_sel=1)
- in_op  input  3  operation select
- in_acc_sel  input  1  1: operand B = accumulator, and accumulator <= result
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  registered result
- out_zero  output  1  out_data == 0
- out_parity  output  1  XOR-reduction of out_data (1 = odd number of ones)
- acc_q  output  WIDTH  current accumulator value
- txn_count  output  CNT_W  number of accepted input transactions, modulo 2^CNT_W

Behaviour:
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A (B ignored).
- Operand B used: opb = in_acc_sel ? acc_q : in_b. Result is f(in_a, opb), bitwise, exactly WIDTH bits, with no carries.
- Handshake: in_ready = !out_valid || out_ready (combinational, no registered bubble). Accept = in_valid && in_ready.
- On accept:
  - out_data <= result; out_zero and out_parity are computed from that same result.
  - out_valid <= 1.
  - txn_count <= txn_count + 1, wrapping from all-ones to 0.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- Output stall: while out_valid=1 && out_ready=0, out_data and the flags hold stable and in_ready=0.
- Drain: if out_valid=1 && out_ready=1 with no accept in the same cycle, out_valid <= 0 and out_data holds its last value.
- Accumulator:
  - On accept with in_acc_sel=1: acc_q <= result.
  - On accept with in_acc_sel=0: acc_q is unchanged.
- acc_clr=1: acc_q <= 0 regardless of any accept.
  - If acc_clr and an in_acc_sel accept occur in the same cycle, the operation uses the pre-clear acc_q, out_data gets that result, and acc_q becomes 0 (clear wins the acc_q update).
- in_valid while in_ready=0: nothing is captured. The producer must hold its inputs stable.
- Reset (any cycle, including mid-stall):
  - out_valid=0, out_data=0, out_zero=0, out_parity=0, acc_q=0, txn_count=0.
  - A pending output is discarded.
  - in_ready reads 1 in the first cycle after reset.
  - rst overrides acc_clr and any accept.
- No X propagation: in_op is fully decoded, so there is no default-to-X case.

Decomposition:
- Shared package logic_pkg:
  - op-code constants OP_AND..OP_PASS as 3-bit localparams/typedef enum op_e
  - helper function for parity reduction.
- Sub-module logic_op_core: purely combinational, parameter WIDTH, ports (a, b, op) -> y. It is reused by later gate/logic blocks.
- logic_unit_pipe holds the handshake, output register, accumulator and counter.

Test Plan:
- Basic ops, WIDTH=8, out_ready=1, a=8'hA5, b=8'h3C, ops 000..111 back-to-back:
  - out_data sequence 24, BD, 99, DB, 42, 66, 5A, A5, one per cycle, starting 1 cycle after the first accept.
  - out_parity 0,0,0,0,0,0,0,0.
  - txn_count=8 at end.
- Zero flag: a=8'h0F, b=8'hF0, op AND -> out_data=8'h00, out_zero=1, out_parity=0.
- Accumulate: acc_clr pulse, then in_acc_sel=1, op OR, a=01, 02, 80 on consecutive cycles:
  - out_data 01, 03, 83; acc_q=8'h83.
  - Then acc_clr together with an accept (op OR, a=04): out_data=87, acc_q=00.
- Backpressure:
  - out_ready=0, present A then B on consecutive cycles: A captured, in_ready=0 from the next cycle, out_data stays A.
  - Raise out_ready: A consumed and B accepted in the same cycle, B appears next cycle, no loss or duplication.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> next cycle out_valid=0, out_data=0, acc_q=0, txn_count=0, in_ready=1.
- Counter wrap, CNT_W=4: 17 accepts -> txn_count reads 0 after the 16th and 1 after the 17th.
